// File: rtl/obi_ram_arbiter.sv
// Two-to-one OBI arbiter: instruction fetch and data share one memory port.
// Address phases are round-robin with a grant lock; responses are steered back in order via an ID FIFO.
module obi_ram_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 instr_req_i,
    output logic                                 instr_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                instr_addr_i,
    output logic                                 instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]                instr_rdata_o,
    input  logic                                 data_req_i,
    output logic                                 data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                data_addr_i,
    input  logic                                 data_we_i,
    input  logic [DATA_WIDTH/8-1:0]              data_be_i,
    input  logic [DATA_WIDTH-1:0]                data_wdata_i,
    output logic                                 data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                data_rdata_o,
    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    output logic [DATA_WIDTH/8-1:0]              mem_be_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic                                 mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
    output logic                                 rsp_error_o
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_lock_id;
    logic                 r_last_id;
    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic                 r_rsp_error;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_instr_elig;
    logic                 w_data_elig;
    logic                 w_sel_id;
    logic                 w_mem_req;
    logic                 w_hs;
    logic                 w_pop;
    logic                 w_head_id;

    assign w_full       = (r_count == CW'(MAX_OUTSTANDING));
    assign w_empty      = (r_count == '0);
    assign w_instr_elig = instr_req_i & ~w_full;
    assign w_data_elig  = data_req_i & ~w_full;

    // State register; r_last_id resets to instr so the first tie goes to data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_lock_id <= 1'b0;
            r_last_id <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_mem_req && !mem_gnt_i)
                r_lock_id <= w_sel_id;
            if (w_hs)
                r_last_id <= w_sel_id;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_mem_req && !mem_gnt_i) w_state_nxt = S_LOCKED;
            S_LOCKED: if (mem_gnt_i)               w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // A locked request skips the full check: it was eligible when it locked.
    always_comb begin
        w_sel_id  = 1'b0;
        w_mem_req = 1'b0;
        case (r_state)
            S_LOCKED: begin
                w_sel_id  = r_lock_id;
                w_mem_req = 1'b1;
            end
            default: begin
                w_mem_req = w_instr_elig | w_data_elig;
                w_sel_id  = (w_instr_elig & w_data_elig) ? ~r_last_id : w_data_elig;
            end
        endcase
    end

    assign w_hs        = w_mem_req & mem_gnt_i;
    assign mem_req_o   = w_mem_req;
    assign mem_addr_o  = w_sel_id ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = w_sel_id ? data_we_i    : 1'b0;
    assign mem_be_o    = w_sel_id ? data_be_i    : {BW{1'b1}};
    assign mem_wdata_o = w_sel_id ? data_wdata_i : '0;
    assign instr_gnt_o = w_hs & ~w_sel_id;
    assign data_gnt_o  = w_hs & w_sel_id;

    assign w_head_id      = r_fifo[r_rptr];
    assign w_pop          = mem_rvalid_i & ~w_empty;
    assign instr_rvalid_o = w_pop & ~w_head_id;
    assign data_rvalid_o  = w_pop & w_head_id;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (w_hs)
            r_fifo[r_wptr] <= w_sel_id;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            if (w_hs)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (mem_rvalid_i && w_empty)
                r_rsp_error <= 1'b1;
        end
    end

    assign outstanding_o = r_count;
    assign rsp_error_o   = r_rsp_error;

endmodule
